// File: rtl/uart_rx_ctrl.sv
// Register-mapped control block for a UART receiver: baud tick generator, receive FIFO and bus registers.
// Define UART_RX_IRQ_EN to enable the level interrupt output and the CTRL.irq_en bit.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] DVSR_RST   = 32'd5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_ready,
  output logic        tick_en,
  output logic        rx_en,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   dvsr_q, dvsr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rdy_q, push_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d;
  logic [27:0]   tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic          irq_q, irq_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic        wr, rd, ctrl_wr, dvsr_wr, run, flush, full, not_empty, pop, push, push_ok;
  logic [27:0] div;
  logic [31:0] status;

  assign wr        = sel & we;
  assign rd        = sel & ~we;
  assign ctrl_wr   = wr && (addr == 2'd3);
  assign dvsr_wr   = wr && (addr == 2'd2);
  assign run       = (state_q == ST_RUN);
  assign flush     = (state_q == ST_FLUSH);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign not_empty = (count_q != '0);
  // The FIFO reads as empty during FLUSH so a DATA read there neither pops nor returns stale data.
  assign pop       = rd && (addr == 2'd0) && not_empty && !flush;
  assign push      = push_q & run;
  assign push_ok   = push & (~full | pop);
  assign div       = dvsr_q[31:4];
  assign status    = {16'h0, 8'(count_q), 5'b0, ovr_q, full, not_empty};

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    dvsr_d   = dvsr_q;
    if (dvsr_wr) dvsr_d = wdata;
    if (ctrl_wr) begin
      en_d = wdata[0];
`ifdef UART_RX_IRQ_EN
      irq_en_d = wdata[1];
`endif
      if (wdata[2])      state_d = ST_FLUSH;
      else if (wdata[0]) state_d = ST_RUN;
      else               state_d = ST_DISABLED;
    end else if (flush) begin
      state_d = en_q ? ST_RUN : ST_DISABLED;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovr_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push && full && !pop) ovr_d = 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (addr)
        2'd0:    rdata_d = pop ? {24'h0, mem[rd_ptr_q]} : '0;
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = dvsr_q;
        default: rdata_d = {29'h0, 1'b0, irq_en_q, en_q};
      endcase
    end
  end

  // Pulse is registered, so the counter wraps one cycle early to keep the period at div.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    if (!run || dvsr_wr) begin
      tick_cnt_d = '0;
    end else if (div != '0) begin
      if (tick_cnt_q == div - 28'd1) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 28'd1;
      end
    end
  end

  always_comb begin
`ifdef UART_RX_IRQ_EN
    irq_d = irq_en_q & (not_empty | ovr_q);
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_DISABLED;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      dvsr_q     <= DVSR_RST;
      rdata_q    <= '0;
      rdy_q      <= 1'b0;
      push_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      dvsr_q     <= dvsr_d;
      rdata_q    <= rdata_d;
      rdy_q      <= rx_byte_ready;
      push_q     <= rx_byte_ready & ~rdy_q & run;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= rx_byte;
  end

  assign rdata   = rdata_q;
  assign rx_en   = run;
  assign tick_en = run & ((div == '0) | tick_q);
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed plus randomized bench for uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  rx_byte;
  logic        rx_byte_ready, tick_en, rx_en, irq;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  q[$];
  bit          m_ovr, m_en, m_irq_en, m_run;
  logic [31:0] m_dvsr;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DVSR_RST(32'd5208)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rx_byte(rx_byte), .rx_byte_ready(rx_byte_ready),
    .tick_en(tick_en), .rx_en(rx_en), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(q.size()), 5'b0, m_ovr, (q.size() == DEPTH), (q.size() != 0)};
  endfunction

  function automatic logic exp_irq();
`ifdef UART_RX_IRQ_EN
    return m_irq_en & ((q.size() != 0) | m_ovr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_ctrl();
    return {30'h0, m_irq_en, m_en};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovr = 0; m_en = 0; m_irq_en = 0; m_run = 0;
    m_dvsr = 32'd5208;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    step();
    sel = 0; we = 0;
    if (a == 2'd2) m_dvsr = d;
    if (a == 2'd3) begin
      m_en = d[0];
`ifdef UART_RX_IRQ_EN
      m_irq_en = d[1];
`endif
      m_run = d[0];
      if (d[2]) begin
        q.delete();
        m_ovr = 0;
        step();
      end
    end
  endtask

  task automatic read_check(input logic [1:0] a, input string tag);
    logic [31:0] exp;
    case (a)
      2'd0:    exp = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
      2'd1:    exp = exp_status();
      2'd2:    exp = m_dvsr;
      default: exp = exp_ctrl();
    endcase
    sel = 1; we = 0; addr = a;
    step();
    sel = 0;
    check(tag, rdata, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_byte_ready = 1;
    repeat (3) step();
    rx_byte_ready = 0;
    step();
    if (m_run) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovr = 1;
    end
  endtask

  task automatic tick_window(input int n, input string tag);
    int unsigned dv;
    logic e;
    dv = m_dvsr >> 4;
    for (int j = 0; j < n; j++) begin
      if (!m_run)       e = 0;
      else if (dv == 0) e = 1;
      else              e = (j > 0) && (j % dv == 0);
      check(tag, tick_en, e);
      step();
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] exp, d;
    rst = 0; sel = 0; we = 0; addr = 0; wdata = 0; rx_byte = 0; rx_byte_ready = 0;
    model_reset();
    repeat (3) step();
    rst = 1;
    step();

    check("rst_rdata", rdata, 0);
    check("rst_tick", tick_en, 0);
    check("rst_rx_en", rx_en, 0);
    check("rst_irq", irq, 0);
    read_check(2, "rst_dvsr");
    read_check(3, "rst_ctrl");
    read_check(1, "rst_status");

    send_byte(8'h99);
    read_check(1, "disabled_no_push");

    bus_write(3, 32'h1);
    check("run_rx_en", rx_en, 1);
    bus_write(2, 32'd160);
    tick_window(35, "tick_div10");
    bus_write(2, 32'd8);
    tick_window(12, "tick_const");
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(16, 16 * 13 + 15);
      bus_write(2, d);
      tick_window(3 * int'(d >> 4) + 2, "tick_rand");
    end
    read_check(2, "dvsr_readback");
    bus_write(3, 32'h0);
    check("dis_rx_en", rx_en, 0);
    tick_window(6, "tick_disabled");
    bus_write(3, 32'h1);

    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    check("status_3", exp_status(), 32'h0301);
    read_check(1, "status_3b");
    for (int k = 0; k < 3; k++) read_check(0, "data_abc");
    read_check(1, "status_empty");
    read_check(0, "data_empty");

    for (int k = 0; k < 9; k++) send_byte(8'($urandom_range(0, 255)));
    check("ovf_model", exp_status(), 32'h0807);
    read_check(1, "status_ovf");
    for (int k = 0; k < DEPTH; k++) read_check(0, "data_ovf");
    read_check(1, "status_ovf_drained");

    bus_write(3, 32'h5);
    read_check(1, "status_flush");
    check("flush_run", rx_en, 1);
    read_check(3, "ctrl_flush_reads0");

    for (int k = 0; k < DEPTH; k++) send_byte(8'($urandom_range(0, 255)));
    b = 8'($urandom_range(0, 255));
    rx_byte = b;
    rx_byte_ready = 1;
    step();
    exp = {24'h0, q.pop_front()};
    q.push_back(b);
    sel = 1; we = 0; addr = 0;
    step();
    sel = 0;
    check("coincident_pop", rdata, exp);
    step();
    rx_byte_ready = 0;
    step();
    read_check(1, "status_coincident");
    for (int k = 0; k < DEPTH; k++) read_check(0, "data_coincident");

    bus_write(3, 32'h3);
    read_check(3, "ctrl_irq_bit");
    send_byte(8'h5a);
    check("irq_set", irq, exp_irq());
    read_check(0, "data_irq");
    step();
    check("irq_clear", irq, exp_irq());
    repeat (3) step();
    check("rdata_hold", rdata, 32'h5a);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0, 1: send_byte(8'($urandom_range(0, 255)));
        2:    read_check(0, "rand_data");
        default: read_check(1, "rand_status");
      endcase
      step();
      check("rand_irq", irq, exp_irq());
    end

    bus_write(3, 32'h1);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)));
    read_check(2, "pre_rst_dvsr");
    bus_write(2, 32'd480);
    rx_byte_ready = 1;
    #2 rst = 0;
    #1;
    model_reset();
    check("midrst_rx_en", rx_en, 0);
    check("midrst_rdata", rdata, 0);
    step();
    rx_byte_ready = 0;
    step();
    rst = 1;
    step();
    check("post_rst_rdata", rdata, 0);
    check("post_rst_tick", tick_en, 0);
    check("post_rst_rx_en", rx_en, 0);
    check("post_rst_irq", irq, 0);
    read_check(2, "post_rst_dvsr");
    read_check(3, "post_rst_ctrl");
    read_check(1, "post_rst_status");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter DVSR_RST, default 32'd5208, divisor value loaded at reset.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sel  input  1  bus access strobe, one cycle per access.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; qualified by sel.
REQ-007 SHALL have port addr  input  2  register select: 0 DATA, 1 STATUS, 2 DVSR, 3 CTRL.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data, registered.
REQ-010 SHALL have port rx_byte  input  8  byte from uart_receiver data_out.
REQ-011 SHALL have port rx_byte_ready  input  1  uart_receiver byte_ready level.
REQ-012 SHALL have port tick_en  output  1  16x oversample enable pulse for the receiver.
REQ-013 SHALL have port rx_en  output  1  receiver enable, high in RUN only.
REQ-014 SHALL have port irq  output  1  interrupt request, level.

Function
REQ-015 SHALL implement FSM DISABLED -> RUN on CTRL.en=1 write; RUN -> DISABLED on CTRL.en=0 write; any state -> FLUSH on CTRL.flush=1 write; FLUSH lasts exactly one cycle, then goes to RUN if en=1, else DISABLED.
REQ-016 SHALL, in FLUSH, clear FIFO pointers, count and overrun flag; flush and en written together: flush wins this cycle, en applied on exit.
REQ-017 SHALL generate tick_en as a one-cycle pulse every (DVSR>>4) cycles in RUN; when DVSR[31:4]==0, tick_en=1 every RUN cycle; counter held at 0 and tick_en=0 outside RUN.
REQ-018 SHALL restart the tick counter at 0 on any DVSR write; first pulse (DVSR>>4) cycles later.
REQ-019 SHALL detect the 0->1 edge of rx_byte_ready (one-register delay) and push rx_byte in the cycle after the edge, RUN only.
REQ-020 SHALL, on push when FIFO full and no pop that cycle, drop the byte and set sticky overrun.
REQ-021 SHALL, on simultaneous push and pop when full, perform both; count unchanged; no overrun.
REQ-022 SHALL, on a DATA read, return the FIFO head in rdata next cycle and pop it; read when empty returns 0 and changes nothing.
REQ-023 SHALL return STATUS = {count[7:0] in [15:8], overrun in [2], full in [1], not_empty in [0]}, other bits 0.
REQ-024 SHALL return DVSR as written (32 bits) and CTRL = {irq_en [1], en [0]}; flush (bit 2) reads 0.
REQ-025 SHALL ignore writes to DATA and STATUS; SHALL have read latency of exactly 1 cycle; rdata holds its value when there is no read.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL on rst low: FSM DISABLED, FIFO empty, overrun 0, DVSR = DVSR_RST, CTRL = 0, rdata 0, tick_en 0, rx_en 0, irq 0, edge register 0.
REQ-028 SHALL discard FIFO contents and any in-progress edge when reset is asserted mid-operation.

Configuration
REQ-029 SHALL, with UART_RX_IRQ_EN defined, drive irq = irq_en & (not_empty | overrun), registered.
REQ-030 SHALL, without UART_RX_IRQ_EN, tie irq to 0, make CTRL bit 1 read-only 0, and ignore writes to it.

Verification
REQ-031 SHALL cover: DVSR=160, en=1 -> tick_en pulses every 10 cycles; DVSR=8 -> tick_en constantly 1.
REQ-032 SHALL cover: three rx_byte_ready edges with 0x41,0x42,0x43 -> STATUS=0x0301; three DATA reads return 0x41,0x42,0x43; then STATUS=0.
REQ-033 SHALL cover: 9 bytes with FIFO_DEPTH=8 -> STATUS[2]=1, count 8, 9th byte lost; CTRL write 0x5 -> next cycle STATUS=0, FSM RUN.
REQ-034 SHALL cover: FIFO full, DATA read coincident with push -> no overrun, count stays 8, order preserved.
REQ-035 SHALL cover: irq_en=1, one byte received -> irq=1; DATA read -> irq=0 (with UART_RX_IRQ_EN); irq stuck 0 without it.
REQ-036 SHALL cover: rst pulsed low with 4 bytes queued -> all outputs at REQ-027 values, DVSR reads 5208.
